// File: rtl/field_slice_stage.sv
// Streaming bit-field extractor: in_data[LEFT:RIGHT] -> extend -> 2-entry skid buffer.
// Optional per-entry field parity output when FIELD_SLICE_PARITY_EN is defined.
module field_slice_stage #(
  parameter int DATA_W   = 16,
  parameter int LEFT     = 15,
  parameter int RIGHT    = 8,
  parameter int OUT_W    = 8,
  parameter int SIGN_EXT = 0,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
`ifdef FIELD_SLICE_PARITY_EN
  output logic              out_parity,
`endif
  output logic [CNT_W-1:0]  xfer_count
);

  localparam int FIELD_W = LEFT - RIGHT + 1;

  if (LEFT >= DATA_W || RIGHT > LEFT || OUT_W < FIELD_W) begin : g_bad_params
    $fatal(1, "field_slice_stage: illegal LEFT/RIGHT/OUT_W for DATA_W");
  end

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t                      r_state;
  logic                        r_rd_ptr;
  logic                        r_wr_ptr;
  logic [OUT_W-1:0]            r_data [2];
  logic [CNT_W-1:0]            r_cnt;
  logic [FIELD_W-1:0]          w_field;
  logic [OUT_W-1:0]            w_ext;
  logic                        w_accept;
  logic                        w_xfer;

  assign w_field = in_data[LEFT:RIGHT];

  if (OUT_W > FIELD_W) begin : g_extend
    logic w_fill;
    assign w_fill = (SIGN_EXT != 0) ? w_field[FIELD_W-1] : 1'b0;
    assign w_ext  = {{(OUT_W-FIELD_W){w_fill}}, w_field};
  end else begin : g_no_extend
    assign w_ext = w_field;
  end

  // in_ready depends only on registered state and rst, never on out_ready.
  assign in_ready   = (r_state != S_FULL) && !rst;
  assign out_valid  = (r_state != S_EMPTY);
  assign out_data   = out_valid ? r_data[r_rd_ptr] : '0;
  assign xfer_count = r_cnt;
  assign w_accept   = in_valid && in_ready;
  assign w_xfer     = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_EMPTY;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_data[r_wr_ptr] <= w_ext;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_xfer) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
      case (r_state)
        S_EMPTY: if (w_accept) r_state <= S_ONE;
        S_ONE: begin
          if (w_accept && !w_xfer)      r_state <= S_FULL;
          else if (!w_accept && w_xfer) r_state <= S_EMPTY;
        end
        S_FULL:  if (w_xfer) r_state <= S_ONE;
        default: r_state <= S_EMPTY;
      endcase
    end
  end

`ifdef FIELD_SLICE_PARITY_EN
  logic r_par [2];

  // Parity covers the raw field bits, so it travels with its entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par[0] <= 1'b0;
      r_par[1] <= 1'b0;
    end else if (w_accept) begin
      r_par[r_wr_ptr] <= ^w_field;
    end
  end

  assign out_parity = out_valid ? r_par[r_rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_field_slice_stage.sv
// Directed bench for field_slice_stage: four parameterisations driven in lockstep.
// Covers FIELD_SLICE_PARITY_EN when that macro is defined for the build.
module tb_field_slice_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        out_ready = 1'b0;

  logic        d_in_ready, d_out_valid;
  logic [7:0]  d_out_data, d_cnt;
  logic        sx_in_ready, sx_out_valid;
  logic [15:0] sx_out_data;
  logic [7:0]  sx_cnt;
  logic        zx_in_ready, zx_out_valid;
  logic [15:0] zx_out_data;
  logic [7:0]  zx_cnt;
  logic        c4_in_ready, c4_out_valid;
  logic [7:0]  c4_out_data;
  logic [3:0]  c4_cnt;
`ifdef FIELD_SLICE_PARITY_EN
  logic        d_par, sx_par, zx_par, c4_par;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  field_slice_stage u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
`ifdef FIELD_SLICE_PARITY_EN
    .out_parity(d_par),
`endif
    .xfer_count(d_cnt));

  field_slice_stage #(.OUT_W(16), .SIGN_EXT(1)) u_sx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sx_in_ready), .in_data(in_data),
    .out_valid(sx_out_valid), .out_ready(out_ready), .out_data(sx_out_data),
`ifdef FIELD_SLICE_PARITY_EN
    .out_parity(sx_par),
`endif
    .xfer_count(sx_cnt));

  field_slice_stage #(.OUT_W(16), .SIGN_EXT(0)) u_zx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(zx_in_ready), .in_data(in_data),
    .out_valid(zx_out_valid), .out_ready(out_ready), .out_data(zx_out_data),
`ifdef FIELD_SLICE_PARITY_EN
    .out_parity(zx_par),
`endif
    .xfer_count(zx_cnt));

  field_slice_stage #(.CNT_W(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c4_in_ready), .in_data(in_data),
    .out_valid(c4_out_valid), .out_ready(out_ready), .out_data(c4_out_data),
`ifdef FIELD_SLICE_PARITY_EN
    .out_parity(c4_par),
`endif
    .xfer_count(c4_cnt));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    step();
    check("rst_valid", 32'(d_out_valid), 32'h0);
    check("rst_data", 32'(d_out_data), 32'h0);
    check("rst_cnt", 32'(d_cnt), 32'h0);
    check("rst_ready", 32'(d_in_ready), 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_rdy", 32'(d_in_ready), 32'h1);
    check("post_rst_vld", 32'(d_out_valid), 32'h0);

    // Basic push of 0x1234 -> 0x12
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
    step();
    in_valid = 1'b0;
    check("basic_valid", 32'(d_out_valid), 32'h1);
    check("basic_data", 32'(d_out_data), 32'h12);
    check("basic_sx", 32'(sx_out_data), 32'h0012);
    step();
    check("basic_cnt", 32'(d_cnt), 32'h1);
    check("basic_empty", 32'(d_out_valid), 32'h0);

    // Sign versus zero extension of 0x80
    in_valid = 1'b1; in_data = 16'h8000;
    step();
    in_valid = 1'b0;
    check("sext_16", 32'(sx_out_data), 32'hFF80);
    check("zext_16", 32'(zx_out_data), 32'h0080);
    check("ext_8", 32'(d_out_data), 32'h80);
    step();
    check("ext_cnt", 32'(d_cnt), 32'h2);

    // Backpressure: third word must wait upstream
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hAB00;
    step();
    check("bp_rdy1", 32'(d_in_ready), 32'h1);
    in_data = 16'hCD00;
    step();
    check("bp_rdy2", 32'(d_in_ready), 32'h0);
    check("bp_head1", 32'(d_out_data), 32'hAB);
    in_data = 16'hEF00;
    step();
    check("bp_hold_rdy", 32'(d_in_ready), 32'h0);
    check("bp_hold_head", 32'(d_out_data), 32'hAB);
    out_ready = 1'b1;
    step();
    check("bp_out2", 32'(d_out_data), 32'hCD);
    check("bp_cnt3", 32'(d_cnt), 32'h3);
    step();
    in_valid = 1'b0;
    check("bp_out3", 32'(d_out_data), 32'hEF);
    check("bp_cnt4", 32'(d_cnt), 32'h4);
    step();
    check("bp_cnt5", 32'(d_cnt), 32'h5);
    check("bp_empty", 32'(d_out_valid), 32'h0);

    // Streaming: one word per cycle for 10 words
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 16'((16'h10 + k) << 8);
      step();
      check("stream_data", 32'(d_out_data), 32'(16'h10 + k));
      check("stream_rdy", 32'(d_in_ready), 32'h1);
    end
    in_valid = 1'b0;
    step();
    check("stream_cnt", 32'(d_cnt), 32'd15);
    check("c4_at_15", 32'(c4_cnt), 32'd15);
    check("stream_empty", 32'(d_out_valid), 32'h0);

    // Counter wrap on CNT_W=4, field 0x13 parity
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1300;
    step();
    in_valid = 1'b0;
    check("par_data", 32'(d_out_data), 32'h13);
`ifdef FIELD_SLICE_PARITY_EN
    check("par_bit", 32'(d_par), 32'h1);
`endif
    out_ready = 1'b1;
    step();
    check("c4_wrap0", 32'(c4_cnt), 32'd0);
    check("cnt_16", 32'(d_cnt), 32'd16);
    in_valid = 1'b1; in_data = 16'h2400;
    step();
    in_valid = 1'b0;
`ifdef FIELD_SLICE_PARITY_EN
    check("par_bit0", 32'(d_par), 32'h0);
`endif
    step();
    check("c4_wrap1", 32'(c4_cnt), 32'd1);

    // Asynchronous reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h5500;
    step();
    in_data = 16'h6600;
    step();
    in_valid = 1'b0;
    check("full_rdy", 32'(d_in_ready), 32'h0);
    check("full_vld", 32'(d_out_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_vld", 32'(d_out_valid), 32'h0);
    check("arst_rdy", 32'(d_in_ready), 32'h0);
    check("arst_data", 32'(d_out_data), 32'h0);
    check("arst_cnt", 32'(d_cnt), 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("rel_rdy", 32'(d_in_ready), 32'h1);
    check("rel_vld", 32'(d_out_valid), 32'h0);
    out_ready = 1'b1;
    step();
    check("no_stale_vld", 32'(d_out_valid), 32'h0);
    check("no_stale_cnt", 32'(d_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/field_slice_stage.md
Name: field_slice_stage

Overview:
Streaming bit-field extractor with a valid/ready handshake. It is the run-time counterpart of the constant part-select `SOME_VALUE[15:8]` that feeds a parameter into a downstream consumer module. Each accepted input word has `in_data[LEFT:RIGHT]` extracted, optionally sign-extended, and buffered in a 2-entry skid buffer that feeds the consumer stage. Parameters are plain module parameters so the VPI parameter and param-assign examples can also introspect this block.

Parameters:
- DATA_W, 16, input word width.
- LEFT, 15, MSB index of the slice; must be < DATA_W.
- RIGHT, 8, LSB index of the slice; must be <= LEFT.
- OUT_W, 8, output width; must be >= FIELD_W, where FIELD_W = LEFT-RIGHT+1.
- SIGN_EXT, 0, 1 = sign-extend the field to OUT_W; 0 = zero-extend.
- CNT_W, 8, width of the output transfer counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept a word.
- in_data  in  DATA_W  upstream word.
- out_valid  out  1  field available.
- out_ready  in  1  downstream accepts the field.
- out_data  out  OUT_W  extracted field, extended to OUT_W.
- xfer_count  out  CNT_W  number of completed output handshakes, modulo 2^CNT_W.

Behaviour:
- Reset is asynchronous and active-high on `rst`. While `rst` = 1:
  - out_valid = 0, out_data = 0, xfer_count = 0, in_ready = 0.
  - Both buffer entries are invalidated.
  - This happens immediately on assertion, not at the next edge.
- First cycle after `rst` deasserts: in_ready = 1.
- Elaboration check: violating any parameter constraint (LEFT < DATA_W, RIGHT <= LEFT, OUT_W >= FIELD_W) causes $fatal at elaboration.
- Transfer rules:
  - Accept occurs when in_valid && in_ready at the edge.
  - Output transfer occurs when out_valid && out_ready at the edge.
- Extraction: field = in_data[LEFT:RIGHT], captured at accept.
  - Upper OUT_W-FIELD_W bits = field MSB when SIGN_EXT = 1, else 0.
  - When FIELD_W == OUT_W, no extension is applied.
- Latency: a word accepted at edge N is visible on out_valid/out_data after edge N (one cycle). There is no combinational in→out path.
- Occupancy state machine (registered):
  - EMPTY: accept → ONE.
  - ONE: accept with no output transfer → FULL; output transfer with no accept → EMPTY; accept and output transfer together → ONE (new word becomes head next cycle).
  - FULL: output transfer → ONE; accept is impossible in FULL.
- Output and ready derivation:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL) && !rst. It must not depend combinationally on out_ready.
- Ordering: strict FIFO. out_data always shows the head entry and is held stable while out_valid && !out_ready.
- Input ignoring: in_data is ignored when the transfer is not accepted. in_valid while in_ready = 0 has no effect, and the upstream must hold the word.
- xfer_count: increments by 1 on every output transfer and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: buffered words are discarded, not emitted. xfer_count clears.

Optional Feature:
FIELD_SLICE_PARITY_EN
- Defined:
  - Adds output port `out_parity` (1 bit) = XOR of the FIELD_W extracted bits, before extension.
  - It is stored per buffer entry and aligned with out_data.
  - Reset value 0.
- Undefined: the port and its storage are absent; behaviour is otherwise identical.

Test Plan:
- Defaults, out_ready = 1, push in_data = 0x1234 → next cycle out_valid = 1, out_data = 0x12, then xfer_count = 1.
- SIGN_EXT = 1, OUT_W = 16, in_data = 0x8000 → out_data = 0xFF80; with SIGN_EXT = 0 → 0x0080.
- Backpressure, out_ready = 0:
  - Push 0xAB00, 0xCD00, 0xEF00 back-to-back → in_ready drops after the 2nd accept, and 0xEF00 is held upstream.
  - Raise out_ready → outputs 0xAB, 0xCD, 0xEF in order, no loss or duplicate.
- State ONE with in_valid = 1 and out_ready = 1 continuously for 10 words → one word per cycle, state stays ONE, xfer_count = 10.
- CNT_W = 4, 17 transfers → xfer_count sequence reaches 15, then 0, then 1.
- FULL state: assert rst mid-cycle → out_valid = 0 and in_ready = 0 immediately. After deassert → in_ready = 1 and out_valid = 0 with no stale data. With FIELD_SLICE_PARITY_EN defined, field 0x13 gives out_parity = 1.
